// File: rtl/ysyx_22040750_mem_pkg.sv
// Shared types and constants for the memory arbiter: FSM encodings and AXI burst constants.
package ysyx_22040750_mem_pkg;

  typedef enum logic [4:0] {
    R_IDLE    = 5'b00001,
    R_AR_IC   = 5'b00010,
    R_AR_DC   = 5'b00100,
    R_DATA_IC = 5'b01000,
    R_DATA_DC = 5'b10000
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wstate_e;

  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [7:0] BURST_LEN_LINE = 8'd3;
  localparam logic [7:0] BURST_LEN_MMIO = 8'd0;

endpackage

// File: rtl/ysyx_22040750_arb2.sv
// Two-requester grant logic; O_gnt[0] = icache, O_gnt[1] = dcache.
// ARB_RR_EN selects round-robin on contention, otherwise dcache has fixed priority.
module ysyx_22040750_arb2 (
`ifdef ARB_RR_EN
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_upd,
`endif
  input  logic       I_req_ic,
  input  logic       I_req_dc,
  output logic [1:0] O_gnt
);

`ifdef ARB_RR_EN
  // Resets to "icache granted last" so the first contended grant goes to the dcache.
  logic last_dc;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) last_dc <= 1'b0;
    else if (I_upd && (I_req_ic || I_req_dc)) last_dc <= O_gnt[1];
  end

  always_comb begin
    O_gnt = 2'b00;
    if (I_req_ic && I_req_dc) O_gnt = last_dc ? 2'b01 : 2'b10;
    else if (I_req_dc)        O_gnt = 2'b10;
    else if (I_req_ic)        O_gnt = 2'b01;
  end
`else
  always_comb begin
    O_gnt = 2'b00;
    if (I_req_dc)      O_gnt = 2'b10;
    else if (I_req_ic) O_gnt = 2'b01;
  end
`endif

endmodule

// File: rtl/ysyx_22040750_mem_arbiter.sv
// Shares one AXI-style memory port between icache (read) and dcache (read/write).
// Optional ARB_RR_EN macro switches read arbitration to round-robin.
module ysyx_22040750_mem_arbiter
  import ysyx_22040750_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic [ADDR_W-1:0] I_ic_araddr,
  input  logic [7:0]        I_ic_arlen,
  input  logic [2:0]        I_ic_arsize,
  input  logic              I_ic_arvalid,
  output logic              O_ic_arready,
  output logic [DATA_W-1:0] O_ic_rdata,
  output logic              O_ic_rvalid,
  output logic              O_ic_rlast,
  input  logic [ADDR_W-1:0] I_dc_araddr,
  input  logic [7:0]        I_dc_arlen,
  input  logic [2:0]        I_dc_arsize,
  input  logic              I_dc_arvalid,
  output logic              O_dc_arready,
  output logic [DATA_W-1:0] O_dc_rdata,
  output logic              O_dc_rvalid,
  output logic              O_dc_rlast,
  input  logic [ADDR_W-1:0] I_dc_awaddr,
  input  logic [7:0]        I_dc_awlen,
  input  logic [2:0]        I_dc_awsize,
  input  logic              I_dc_awvalid,
  output logic              O_dc_awready,
  input  logic [DATA_W-1:0] I_dc_wdata,
  input  logic [7:0]        I_dc_wstrb,
  input  logic              I_dc_wlast,
  input  logic              I_dc_wvalid,
  output logic              O_dc_wready,
  output logic              O_dc_bvalid,
  output logic [ADDR_W-1:0] O_mem_araddr,
  output logic [7:0]        O_mem_arlen,
  output logic [2:0]        O_mem_arsize,
  output logic              O_mem_arvalid,
  input  logic              I_mem_arready,
  input  logic [DATA_W-1:0] I_mem_rdata,
  input  logic              I_mem_rvalid,
  input  logic              I_mem_rlast,
  output logic              O_mem_rready,
  output logic [ADDR_W-1:0] O_mem_awaddr,
  output logic [7:0]        O_mem_awlen,
  output logic [2:0]        O_mem_awsize,
  output logic              O_mem_awvalid,
  input  logic              I_mem_awready,
  output logic [DATA_W-1:0] O_mem_wdata,
  output logic [7:0]        O_mem_wstrb,
  output logic              O_mem_wlast,
  output logic              O_mem_wvalid,
  input  logic              I_mem_wready,
  input  logic              I_mem_bvalid,
  output logic              O_mem_bready,
  output logic [4:0]        O_dbg_rstate,
  output logic [1:0]        O_dbg_wstate
);

  // Handshake: a transfer happens on a rising I_clk where valid && ready are both 1;
  // requesters hold valid and payload stable until ready, and ready never depends on
  // the same channel's valid inside this block.

  rstate_e rstate, rstate_nxt;
  wstate_e wstate, wstate_nxt;

  logic [1:0]        gnt;
  logic              r_idle;
  logic              ic_elig;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [7:0]        ar_len_q;
  logic [2:0]        ar_size_q;

  assign r_idle  = (rstate == R_IDLE);
  // Icache reads wait for write-back to finish so they never fetch a stale line.
  assign ic_elig = I_ic_arvalid && (wstate == W_IDLE);

  ysyx_22040750_arb2 u_arb2 (
`ifdef ARB_RR_EN
    .I_clk   (I_clk),
    .I_rst   (I_rst),
    .I_upd   (r_idle),
`endif
    .I_req_ic(ic_elig),
    .I_req_dc(I_dc_arvalid),
    .O_gnt   (gnt)
  );

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) rstate <= R_IDLE;
    else       rstate <= rstate_nxt;
  end

  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:    if (gnt[1]) rstate_nxt = R_AR_DC;
                 else if (gnt[0]) rstate_nxt = R_AR_IC;
      R_AR_IC:   if (I_mem_arready) rstate_nxt = R_DATA_IC;
      R_AR_DC:   if (I_mem_arready) rstate_nxt = R_DATA_DC;
      R_DATA_IC: if (I_mem_rvalid && I_mem_rlast) rstate_nxt = R_IDLE;
      R_DATA_DC: if (I_mem_rvalid && I_mem_rlast) rstate_nxt = R_IDLE;
      default:   rstate_nxt = R_IDLE;
    endcase
  end

  // Payload is captured at grant so later requester changes cannot corrupt the AR.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_size_q <= '0;
    end else if (r_idle && (gnt != 2'b00)) begin
      ar_addr_q <= gnt[1] ? I_dc_araddr : I_ic_araddr;
      ar_len_q  <= gnt[1] ? I_dc_arlen  : I_ic_arlen;
      ar_size_q <= gnt[1] ? I_dc_arsize : I_ic_arsize;
    end
  end

  always_comb begin
    O_mem_araddr  = '0;
    O_mem_arlen   = '0;
    O_mem_arsize  = '0;
    O_mem_arvalid = 1'b0;
    O_ic_arready  = 1'b0;
    O_dc_arready  = 1'b0;
    O_ic_rdata    = '0;
    O_ic_rvalid   = 1'b0;
    O_ic_rlast    = 1'b0;
    O_dc_rdata    = '0;
    O_dc_rvalid   = 1'b0;
    O_dc_rlast    = 1'b0;
    case (rstate)
      R_AR_IC, R_AR_DC: begin
        O_mem_araddr  = ar_addr_q;
        O_mem_arlen   = ar_len_q;
        O_mem_arsize  = ar_size_q;
        O_mem_arvalid = 1'b1;
        O_ic_arready  = (rstate == R_AR_IC) && I_mem_arready;
        O_dc_arready  = (rstate == R_AR_DC) && I_mem_arready;
      end
      R_DATA_IC: begin
        O_ic_rdata  = I_mem_rdata;
        O_ic_rvalid = I_mem_rvalid;
        O_ic_rlast  = I_mem_rlast;
      end
      R_DATA_DC: begin
        O_dc_rdata  = I_mem_rdata;
        O_dc_rvalid = I_mem_rvalid;
        O_dc_rlast  = I_mem_rlast;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) wstate <= W_IDLE;
    else       wstate <= wstate_nxt;
  end

  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      W_IDLE: if (I_dc_awvalid) wstate_nxt = W_AW;
      W_AW:   if (I_dc_awvalid && I_mem_awready) wstate_nxt = W_DATA;
      W_DATA: if (I_dc_wvalid && I_mem_wready && I_dc_wlast) wstate_nxt = W_RESP;
      W_RESP: if (I_mem_bvalid) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    O_mem_awaddr  = '0;
    O_mem_awlen   = '0;
    O_mem_awsize  = '0;
    O_mem_awvalid = 1'b0;
    O_dc_awready  = 1'b0;
    O_mem_wdata   = '0;
    O_mem_wstrb   = '0;
    O_mem_wlast   = 1'b0;
    O_mem_wvalid  = 1'b0;
    O_dc_wready   = 1'b0;
    O_dc_bvalid   = 1'b0;
    case (wstate)
      W_AW: begin
        O_mem_awaddr  = I_dc_awaddr;
        O_mem_awlen   = I_dc_awlen;
        O_mem_awsize  = I_dc_awsize;
        O_mem_awvalid = I_dc_awvalid;
        O_dc_awready  = I_mem_awready;
      end
      W_DATA: begin
        O_mem_wdata  = I_dc_wdata;
        O_mem_wstrb  = I_dc_wstrb;
        O_mem_wlast  = I_dc_wlast;
        O_mem_wvalid = I_dc_wvalid;
        O_dc_wready  = I_mem_wready;
      end
      W_RESP:  O_dc_bvalid = I_mem_bvalid;
      default: ;
    endcase
  end

  assign O_mem_rready = 1'b1;
  assign O_mem_bready = 1'b1;
  assign O_dbg_rstate = rstate;
  assign O_dbg_wstate = wstate;

endmodule

// File: tb/tb_ysyx_22040750_mem_arbiter.sv
// Directed bench for ysyx_22040750_mem_arbiter: table of single-master reads plus
// hand sequences for contention, write-back blocking, reset mid-burst and (ARB_RR_EN) round-robin.
module tb_ysyx_22040750_mem_arbiter;
  import ysyx_22040750_mem_pkg::*;

  logic        I_clk, I_rst;
  logic [31:0] I_ic_araddr, I_dc_araddr, I_dc_awaddr;
  logic [7:0]  I_ic_arlen, I_dc_arlen, I_dc_awlen, I_dc_wstrb;
  logic [2:0]  I_ic_arsize, I_dc_arsize, I_dc_awsize;
  logic        I_ic_arvalid, I_dc_arvalid, I_dc_awvalid, I_dc_wlast, I_dc_wvalid;
  logic [63:0] I_dc_wdata, I_mem_rdata;
  logic        I_mem_arready, I_mem_rvalid, I_mem_rlast, I_mem_awready, I_mem_wready, I_mem_bvalid;
  logic        O_ic_arready, O_ic_rvalid, O_ic_rlast, O_dc_arready, O_dc_rvalid, O_dc_rlast;
  logic [63:0] O_ic_rdata, O_dc_rdata, O_mem_wdata;
  logic        O_dc_awready, O_dc_wready, O_dc_bvalid;
  logic [31:0] O_mem_araddr, O_mem_awaddr;
  logic [7:0]  O_mem_arlen, O_mem_awlen, O_mem_wstrb;
  logic [2:0]  O_mem_arsize, O_mem_awsize;
  logic        O_mem_arvalid, O_mem_rready, O_mem_awvalid, O_mem_wlast, O_mem_wvalid, O_mem_bready;
  logic [4:0]  O_dbg_rstate;
  logic [1:0]  O_dbg_wstate;

  int n_checks = 0;
  int n_fail   = 0;
  int bcnt     = 0;
  logic [63:0] exp_q[$];

  ysyx_22040750_mem_arbiter dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_ic_araddr(I_ic_araddr), .I_ic_arlen(I_ic_arlen), .I_ic_arsize(I_ic_arsize),
    .I_ic_arvalid(I_ic_arvalid), .O_ic_arready(O_ic_arready),
    .O_ic_rdata(O_ic_rdata), .O_ic_rvalid(O_ic_rvalid), .O_ic_rlast(O_ic_rlast),
    .I_dc_araddr(I_dc_araddr), .I_dc_arlen(I_dc_arlen), .I_dc_arsize(I_dc_arsize),
    .I_dc_arvalid(I_dc_arvalid), .O_dc_arready(O_dc_arready),
    .O_dc_rdata(O_dc_rdata), .O_dc_rvalid(O_dc_rvalid), .O_dc_rlast(O_dc_rlast),
    .I_dc_awaddr(I_dc_awaddr), .I_dc_awlen(I_dc_awlen), .I_dc_awsize(I_dc_awsize),
    .I_dc_awvalid(I_dc_awvalid), .O_dc_awready(O_dc_awready),
    .I_dc_wdata(I_dc_wdata), .I_dc_wstrb(I_dc_wstrb), .I_dc_wlast(I_dc_wlast),
    .I_dc_wvalid(I_dc_wvalid), .O_dc_wready(O_dc_wready), .O_dc_bvalid(O_dc_bvalid),
    .O_mem_araddr(O_mem_araddr), .O_mem_arlen(O_mem_arlen), .O_mem_arsize(O_mem_arsize),
    .O_mem_arvalid(O_mem_arvalid), .I_mem_arready(I_mem_arready),
    .I_mem_rdata(I_mem_rdata), .I_mem_rvalid(I_mem_rvalid), .I_mem_rlast(I_mem_rlast),
    .O_mem_rready(O_mem_rready),
    .O_mem_awaddr(O_mem_awaddr), .O_mem_awlen(O_mem_awlen), .O_mem_awsize(O_mem_awsize),
    .O_mem_awvalid(O_mem_awvalid), .I_mem_awready(I_mem_awready),
    .O_mem_wdata(O_mem_wdata), .O_mem_wstrb(O_mem_wstrb), .O_mem_wlast(O_mem_wlast),
    .O_mem_wvalid(O_mem_wvalid), .I_mem_wready(I_mem_wready),
    .I_mem_bvalid(I_mem_bvalid), .O_mem_bready(O_mem_bready),
    .O_dbg_rstate(O_dbg_rstate), .O_dbg_wstate(O_dbg_wstate)
  );

  // clock / reset
  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  always @(negedge I_clk) if (O_dc_bvalid === 1'b1) bcnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  task automatic idle_inputs();
    I_ic_araddr = '0; I_ic_arlen = '0; I_ic_arsize = '0; I_ic_arvalid = 1'b0;
    I_dc_araddr = '0; I_dc_arlen = '0; I_dc_arsize = '0; I_dc_arvalid = 1'b0;
    I_dc_awaddr = '0; I_dc_awlen = '0; I_dc_awsize = '0; I_dc_awvalid = 1'b0;
    I_dc_wdata = '0; I_dc_wstrb = '0; I_dc_wlast = 1'b0; I_dc_wvalid = 1'b0;
    I_mem_arready = 1'b0; I_mem_rdata = '0; I_mem_rvalid = 1'b0; I_mem_rlast = 1'b0;
    I_mem_awready = 1'b0; I_mem_wready = 1'b0; I_mem_bvalid = 1'b0;
  endtask

  task automatic request(input bit is_dc, input logic [31:0] addr, input logic [7:0] len);
    if (is_dc) begin
      I_dc_araddr = addr; I_dc_arlen = len; I_dc_arsize = AXI_SIZE_8B; I_dc_arvalid = 1'b1;
    end else begin
      I_ic_araddr = addr; I_ic_arlen = len; I_ic_arsize = AXI_SIZE_8B; I_ic_arvalid = 1'b1;
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [31:0] addr, input int b);
    return {32'hd00d_0000 | 32'(b), addr};
  endfunction

  // Bounded wait for the AR to appear on the memory side.
  task automatic wait_ar(input string name);
    int n = 0;
    while (O_mem_arvalid !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    check({name, " ar_seen"}, O_mem_arvalid, 1);
  endtask

  // Completes an AR already presented on the memory port and streams len+1 beats.
  task automatic serve(input bit is_dc, input logic [31:0] addr, input logic [7:0] len, input string name);
    logic [63:0] exp_d;
    check({name, " araddr"}, O_mem_araddr, addr);
    check({name, " arlen"}, O_mem_arlen, len);
    check({name, " arsize"}, O_mem_arsize, AXI_SIZE_8B);
    I_mem_arready = 1'b1;
    #1;
    check({name, " arready_gnt"}, is_dc ? O_dc_arready : O_ic_arready, 1);
    check({name, " arready_other"}, is_dc ? O_ic_arready : O_dc_arready, 0);
    step();
    I_mem_arready = 1'b0;
    if (is_dc) I_dc_arvalid = 1'b0; else I_ic_arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) exp_q.push_back(beat_data(addr, b));
    for (int b = 0; b <= int'(len); b++) begin
      I_mem_rvalid = 1'b1;
      I_mem_rdata  = beat_data(addr, b);
      I_mem_rlast  = (b == int'(len));
      #1;
      exp_d = exp_q.pop_front();
      check({name, " rvalid"}, is_dc ? O_dc_rvalid : O_ic_rvalid, 1);
      check({name, " rdata"}, is_dc ? O_dc_rdata : O_ic_rdata, exp_d);
      check({name, " rlast"}, is_dc ? O_dc_rlast : O_ic_rlast, (b == int'(len)) ? 64'd1 : 64'd0);
      check({name, " other_rvalid"}, is_dc ? O_ic_rvalid : O_dc_rvalid, 0);
      step();
    end
    I_mem_rvalid = 1'b0;
    I_mem_rlast  = 1'b0;
    #1;
    check({name, " back_idle"}, O_dbg_rstate, R_IDLE);
    check({name, " idle_arvalid"}, O_mem_arvalid, 0);
  endtask

  typedef struct {
    bit          is_dc;
    logic [31:0] addr;
    logic [7:0]  len;
    rstate_e     exp_ar_state;
  } rd_vec_t;

  rd_vec_t vecs[4];

  initial begin
    vecs[0] = '{1'b0, 32'h8000_0000, BURST_LEN_LINE, R_AR_IC};
    vecs[1] = '{1'b1, 32'ha000_0048, BURST_LEN_MMIO, R_AR_DC};
    vecs[2] = '{1'b1, 32'h8000_3040, BURST_LEN_LINE, R_AR_DC};
    vecs[3] = '{1'b0, 32'h8000_0100, 8'd1, R_AR_IC};

    idle_inputs();
    I_rst = 1'b1;
    #3;
    check("rst rstate", O_dbg_rstate, R_IDLE);
    check("rst wstate", O_dbg_wstate, W_IDLE);
    check("rst mem_arvalid", O_mem_arvalid, 0);
    check("rst mem_araddr", O_mem_araddr, 0);
    check("rst arready", {O_ic_arready, O_dc_arready}, 0);
    check("rst rvalid", {O_ic_rvalid, O_dc_rvalid, O_ic_rlast, O_dc_rlast}, 0);
    check("rst wr valids", {O_mem_awvalid, O_mem_wvalid, O_mem_wlast, O_dc_bvalid, O_dc_awready, O_dc_wready}, 0);
    check("rst const readies", {O_mem_rready, O_mem_bready}, 2'b11);
    step();
    I_rst = 1'b0;
    step();

    // Contention after reset: dcache first, icache one idle cycle after dcache rlast.
    request(1'b0, 32'h8000_0000, BURST_LEN_LINE);
    request(1'b1, 32'h8000_1000, BURST_LEN_LINE);
    #1;
    check("both latency", O_mem_arvalid, 0);
    step();
    check("both first grant", O_dbg_rstate, R_AR_DC);
    I_dc_araddr = 32'hdead_beef;
    #1;
    check("both payload held", O_mem_araddr, 32'h8000_1000);
    serve(1'b1, 32'h8000_1000, BURST_LEN_LINE, "both dc");
    step();
    check("both second grant", O_dbg_rstate, R_AR_IC);
    serve(1'b0, 32'h8000_0000, BURST_LEN_LINE, "both ic");
    idle_inputs();
    step();

    // Single-master reads from the table.
    foreach (vecs[i]) begin
      request(vecs[i].is_dc, vecs[i].addr, vecs[i].len);
      #1;
      check($sformatf("vec%0d latency", i), O_mem_arvalid, 0);
      step();
      check($sformatf("vec%0d ar_state", i), O_dbg_rstate, vecs[i].exp_ar_state);
      check($sformatf("vec%0d arvalid", i), O_mem_arvalid, 1);
      serve(vecs[i].is_dc, vecs[i].addr, vecs[i].len, $sformatf("vec%0d", i));
      idle_inputs();
      step();
    end

    // Write-back blocks a concurrent icache read until the write FSM is idle again.
    bcnt = 0;
    I_dc_awaddr = 32'h8000_2000; I_dc_awlen = BURST_LEN_LINE; I_dc_awsize = AXI_SIZE_8B;
    I_dc_awvalid = 1'b1;
    #1;
    check("wb aw not yet", O_mem_awvalid, 0);
    step();
    check("wb state aw", O_dbg_wstate, W_AW);
    request(1'b0, 32'h8000_0400, BURST_LEN_LINE);
    I_mem_awready = 1'b1;
    #1;
    check("wb awvalid", O_mem_awvalid, 1);
    check("wb awaddr", O_mem_awaddr, 32'h8000_2000);
    check("wb awlen", O_mem_awlen, BURST_LEN_LINE);
    check("wb awready", O_dc_awready, 1);
    step();
    I_dc_awvalid = 1'b0;
    I_mem_awready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      I_dc_wdata = 64'hcafe_0000_0000_0000 | 64'(b);
      I_dc_wstrb = 8'hff; I_dc_wlast = (b == 3); I_dc_wvalid = 1'b1; I_mem_wready = 1'b1;
      #1;
      check("wb wvalid", O_mem_wvalid, 1);
      check("wb wdata", O_mem_wdata, 64'hcafe_0000_0000_0000 | 64'(b));
      check("wb wlast", O_mem_wlast, (b == 3) ? 64'd1 : 64'd0);
      check("wb wready", O_dc_wready, 1);
      check("wb ic blocked", O_mem_arvalid, 0);
      step();
    end
    I_dc_wvalid = 1'b0; I_dc_wlast = 1'b0; I_mem_wready = 1'b0;
    #1;
    check("wb state resp", O_dbg_wstate, W_RESP);
    check("wb no bvalid yet", O_dc_bvalid, 0);
    step();
    check("wb resp ic blocked", O_mem_arvalid, 0);
    I_mem_bvalid = 1'b1;
    #1;
    check("wb bvalid", O_dc_bvalid, 1);
    step();
    I_mem_bvalid = 1'b0;
    #1;
    check("wb w idle", O_dbg_wstate, W_IDLE);
    check("wb ic still waiting", O_mem_arvalid, 0);
    check("wb bvalid dropped", O_dc_bvalid, 0);
    step();
    check("wb ic granted", O_dbg_rstate, R_AR_IC);
    check("wb bvalid once", 64'(bcnt), 1);
    serve(1'b0, 32'h8000_0400, BURST_LEN_LINE, "wb ic");
    idle_inputs();
    step();

    // Reset in the middle of an icache burst.
    request(1'b0, 32'h8000_0800, BURST_LEN_LINE);
    step();
    I_mem_arready = 1'b1;
    step();
    I_mem_arready = 1'b0;
    I_ic_arvalid = 1'b0;
    I_mem_rvalid = 1'b1; I_mem_rdata = beat_data(32'h8000_0800, 0); I_mem_rlast = 1'b0;
    #1;
    check("rstm beat1", O_ic_rvalid, 1);
    step();
    I_mem_rdata = beat_data(32'h8000_0800, 1);
    I_rst = 1'b1;
    #1;
    check("rstm ic_rvalid", O_ic_rvalid, 0);
    check("rstm valids", {O_mem_arvalid, O_dc_rvalid, O_mem_awvalid, O_mem_wvalid, O_dc_bvalid}, 0);
    check("rstm rstate", O_dbg_rstate, R_IDLE);
    idle_inputs();
    step();
    I_rst = 1'b0;
    step();
    request(1'b0, 32'h8000_0c00, BURST_LEN_LINE);
    #1;
    check("rstm latency", O_mem_arvalid, 0);
    step();
    check("rstm regrant", O_dbg_rstate, R_AR_IC);
    serve(1'b0, 32'h8000_0c00, BURST_LEN_LINE, "rstm ic");
    idle_inputs();
    step();

`ifdef ARB_RR_EN
    // Last grant is the icache here, so persistent contention alternates dc, ic, dc, ic.
    for (int k = 0; k < 4; k++) begin
      bit exp_dc;
      exp_dc = (k % 2 == 0);
      request(1'b0, 32'h8000_0000, BURST_LEN_MMIO);
      request(1'b1, 32'ha000_0048, BURST_LEN_MMIO);
      wait_ar($sformatf("rr%0d", k));
      check($sformatf("rr%0d state", k), O_dbg_rstate, exp_dc ? R_AR_DC : R_AR_IC);
      serve(exp_dc, exp_dc ? 32'ha000_0048 : 32'h8000_0000, BURST_LEN_MMIO, $sformatf("rr%0d", k));
    end
    idle_inputs();
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
